// File: rtl/key_uart_pkg.sv
// Shared types and constants for the key-to-UART character sender.
package key_uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_e;

  // Clock cycles per serial bit, rounded to the nearest integer.
  function automatic int unsigned calcDiv(input longint unsigned clkHz,
                                          input longint unsigned baud);
    return 32'((clkHz + baud / 64'd2) / baud);
  endfunction

endpackage

// File: rtl/key_uart_tx_if.sv
// Key levels in, serial line and status out; master is the debouncer-bank side.
interface key_uart_tx_if #(
  parameter int N_KEYS = 4
) ();

  logic [N_KEYS-1:0] iKeys;
  logic              oTx;
  logic              oBusy;
  logic              oDropped;

  modport master (output iKeys, input oTx, oBusy, oDropped);
  modport slave  (input iKeys, output oTx, oBusy, oDropped);

endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 serialiser: one frame per iStart pulse accepted while idle, DIV cycles per bit.
module uart_tx_8n1
  import key_uart_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic [DATA_BITS-1:0] iData,
  output logic                 oTx,
  output logic                 oBusy
);

  localparam int              CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  logic [1:0]           state;
  logic [CNT_W-1:0]     baudCnt;
  logic [2:0]           bitIdx;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 bitDone;

  assign bitDone = (baudCnt == CNT_LAST);

  // NOTE: all state here is updated with <= so every register samples pre-edge values.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state    <= S_IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      oTx      <= IDLE_LEVEL;
      oBusy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iStart) begin
            state    <= S_START;
            baudCnt  <= '0;
            shiftReg <= iData;
            oTx      <= 1'b0;
            oBusy    <= 1'b1;
          end
        end
        S_START: begin
          if (bitDone) begin
            baudCnt  <= '0;
            bitIdx   <= '0;
            state    <= S_DATA;
            oTx      <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
          end else begin
            baudCnt <= baudCnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bitDone) begin
            baudCnt <= '0;
            if (bitIdx == 3'(DATA_BITS - 1)) begin
              state <= S_STOP;
              oTx   <= IDLE_LEVEL;
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              oTx      <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
            end
          end else begin
            baudCnt <= baudCnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (bitDone) begin
            baudCnt <= '0;
            state   <= S_IDLE;
            oBusy   <= 1'b0;
          end else begin
            baudCnt <= baudCnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          oTx   <= IDLE_LEVEL;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_uart_tx.sv
// Turns debounced key presses into queued ASCII characters sent over an 8N1 UART line.
module key_uart_tx
  import key_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int          N_KEYS    = 4,
  parameter logic [7:0]  CHAR_BASE = 8'h30
) (
  input  logic         iClk,
  input  logic         iRst,
  key_uart_tx_if.slave bus
);

  if (N_KEYS < 1 || N_KEYS > 8) begin : gKeyRange
    $error("key_uart_tx: N_KEYS must be in 1..8");
  end

  localparam int unsigned DIV = calcDiv(64'(CLK_HZ), 64'(BAUD));

  logic [N_KEYS-1:0] keysQ;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] pending;
  logic [N_KEYS-1:0] grant;
  logic [2:0]        grantIdx;
  logic [7:0]        txData;
  logic              busy;
  logic              dropped;

  assign rise = bus.iKeys & ~keysQ;

  // NOTE: defaults first so no path through always_comb leaves a value held (no latch).
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    if (!busy) begin
      // Descending scan: the last hit, i.e. the lowest pending index, wins.
      for (int i = N_KEYS - 1; i >= 0; i--) begin
        if (pending[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
          grantIdx = 3'(i);
        end
      end
    end
  end

  assign txData = CHAR_BASE + {5'b0, grantIdx};

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      keysQ   <= '0;
      pending <= '0;
      dropped <= 1'b0;
    end else begin
      keysQ   <= bus.iKeys;
      // A rise on the key being granted re-arms it rather than counting as a drop.
      pending <= (pending & ~grant) | rise;
      dropped <= |(rise & pending & ~grant);
    end
  end

  uart_tx_8n1 #(
    .DIV (DIV)
  ) uTx (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (|grant),
    .iData  (txData),
    .oTx    (bus.oTx),
    .oBusy  (busy)
  );

  assign bus.oBusy    = busy;
  assign bus.oDropped = dropped;

endmodule

// File: tb/tb_key_uart_tx.sv
// Self-checking bench for key_uart_tx: directed scenarios plus random key activity vs a frame-level model.
module tb_key_uart_tx;

  localparam int unsigned CLK_HZ    = 1_000_000;
  localparam int unsigned BAUD      = 100_000;
  localparam int          DIV       = 10;
  localparam int          NK        = 4;
  localparam bit [7:0]    CHAR_BASE = 8'h30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_uart_tx_if #(.N_KEYS(NK)) bus ();

  key_uart_tx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .N_KEYS    (NK),
    .CHAR_BASE (CHAR_BASE)
  ) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  // Reference model: pending keys as a bitmask, a frame as a start time and a character.
  typedef struct {
    bit [NK-1:0] prevKeys;
    bit [NK-1:0] pend;
    bit          inFrame;
    int          off;
    bit [7:0]    ch;
    bit          tx;
    bit          busy;
    bit          drop;
    bit          granted;
  } mdl_t;

  function automatic mdl_t modelReset();
    mdl_t r;
    r.prevKeys = '0; r.pend = '0; r.inFrame = 1'b0; r.off = 0; r.ch = '0;
    r.tx = 1'b1; r.busy = 1'b0; r.drop = 1'b0; r.granted = 1'b0;
    return r;
  endfunction

  function automatic mdl_t modelStep(mdl_t s, bit [NK-1:0] keys);
    mdl_t        n;
    bit [NK-1:0] rise;
    int          g;
    int          slot;
    n    = s;
    rise = keys & ~s.prevKeys;
    g    = -1;
    if (!s.inFrame)
      for (int i = 0; i < NK; i++)
        if (s.pend[i] && g < 0) g = i;
    n.granted = (g >= 0);
    n.drop    = 1'b0;
    for (int i = 0; i < NK; i++)
      if (rise[i] && s.pend[i] && i != g) n.drop = 1'b1;
    n.pend = s.pend | rise;
    if (g >= 0) n.pend[g] = rise[g];
    if (g >= 0) begin
      n.inFrame = 1'b1;
      n.off     = 0;
      n.ch      = 8'(int'(CHAR_BASE) + g);
    end else if (s.inFrame) begin
      n.off = s.off + 1;
      if (n.off == 10 * DIV) n.inFrame = 1'b0;
    end
    slot = n.off / DIV;
    if (!n.inFrame)     n.tx = 1'b1;
    else if (slot == 0) n.tx = 1'b0;
    else if (slot <= 8) n.tx = n.ch[slot-1];
    else                n.tx = 1'b1;
    n.busy     = n.inFrame;
    n.prevKeys = keys;
    return n;
  endfunction

  mdl_t mdl;
  always @(posedge clk or negedge rst) begin
    if (!rst) mdl <= modelReset();
    else      mdl <= modelStep(mdl, bus.iKeys);
  end

  int       nVec = 0;
  int       nErr = 0;
  int       cyc  = 0;
  int       dropCnt, mdlDropCnt, busyCnt;
  bit [7:0] rxQ[$];
  bit [7:0] expQ[$];
  int       fallQ[$];
  bit       monActive = 1'b0;
  int       monOff;
  bit [7:0] monByte;

  function automatic bit sameBytes(bit [7:0] a[$], bit [7:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock step: per-cycle comparison against the model plus a line receiver.
  task automatic tick();
    int slot;
    @(negedge clk);
    cyc++;
    nVec++;
    if ({bus.oTx, bus.oBusy, bus.oDropped} !== {mdl.tx, mdl.busy, mdl.drop}) begin
      nErr++;
      if (nErr <= 20)
        $display("FAIL cycle_model cyc=%0d tx/busy/drop got %b%b%b want %b%b%b",
                 cyc, bus.oTx, bus.oBusy, bus.oDropped, mdl.tx, mdl.busy, mdl.drop);
    end
    if (mdl.granted) expQ.push_back(mdl.ch);
    if (mdl.drop)    mdlDropCnt++;
    if (bus.oDropped === 1'b1) dropCnt++;
    if (bus.oBusy === 1'b1)    busyCnt++;
    if (!rst) begin
      monActive = 1'b0;
    end else if (!monActive) begin
      if (bus.oTx === 1'b0) begin
        monActive = 1'b1;
        monOff    = 0;
        fallQ.push_back(cyc);
      end
    end else begin
      monOff++;
      if (monOff % DIV == DIV / 2) begin
        slot = monOff / DIV;
        if (slot >= 1 && slot <= 8) monByte[slot-1] = bus.oTx;
        else if (slot == 9) begin
          rxQ.push_back(monByte);
          monActive = 1'b0;
        end
      end
    end
  endtask

  task automatic waitQuiet(input int budget);
    int quiet = 0;
    int n     = 0;
    while (quiet < 5 && n < budget) begin
      tick();
      n++;
      quiet = (bus.oBusy === 1'b0) ? quiet + 1 : 0;
    end
    if (quiet < 5) begin
      nVec++; nErr++;
      $display("FAIL wait_idle timeout after %0d cycles", budget);
    end
  endtask

  task automatic clearObs();
    rxQ.delete(); expQ.delete(); fallQ.delete();
    dropCnt = 0; mdlDropCnt = 0; busyCnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.iKeys = '0;
    repeat (3) tick();
    nVec++;
    if (bus.oTx !== 1'b1) begin nErr++; $display("FAIL reset_tx got %b want 1", bus.oTx); end
    nVec++;
    if (bus.oBusy !== 1'b0) begin nErr++; $display("FAIL reset_busy got %b want 0", bus.oBusy); end
    nVec++;
    if (bus.oDropped !== 1'b0) begin nErr++; $display("FAIL reset_dropped got %b want 0", bus.oDropped); end
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_single_press();
    int       t0;
    bit [7:0] want[$];
    clearObs();
    bus.iKeys = 4'b0001;
    t0 = cyc;
    repeat (50) tick();
    bus.iKeys = '0;
    waitQuiet(400);
    want.push_back(8'h30);
    nVec++;
    if (fallQ.size() != 1 || fallQ[0] - t0 != 2) begin
      nErr++; $display("FAIL single_latency got frames=%0d lat=%0d want 1/2", fallQ.size(), fallQ[0] - t0);
    end
    nVec++;
    if (!sameBytes(rxQ, want)) begin nErr++; $display("FAIL single_char got %p want %p", rxQ, want); end
    nVec++;
    if (busyCnt != 100) begin nErr++; $display("FAIL single_busy_len got %0d want 100", busyCnt); end
  endtask

  task automatic test_simultaneous();
    int       t0;
    bit [7:0] want[$];
    clearObs();
    bus.iKeys = 4'b1010;
    t0 = cyc;
    repeat (10) tick();
    bus.iKeys = '0;
    waitQuiet(400);
    want.push_back(8'h31);
    want.push_back(8'h33);
    nVec++;
    if (!sameBytes(rxQ, want)) begin nErr++; $display("FAIL simul_chars got %p want %p", rxQ, want); end
    nVec++;
    if (fallQ.size() != 2 || fallQ[0] - t0 != 2 || fallQ[1] - t0 != 103) begin
      nErr++; $display("FAIL simul_fall_times got %p (base %0d) want +2,+103", fallQ, t0);
    end
  endtask

  task automatic test_drop();
    bit [7:0] want[$];
    clearObs();
    bus.iKeys = 4'b0001; repeat (5) tick();
    bus.iKeys = 4'b0101; repeat (3) tick();
    bus.iKeys = 4'b0001; repeat (3) tick();
    bus.iKeys = 4'b0101; repeat (3) tick();
    bus.iKeys = '0;
    waitQuiet(500);
    want.push_back(8'h30);
    want.push_back(8'h32);
    nVec++;
    if (dropCnt != 1) begin nErr++; $display("FAIL drop_pulses got %0d want 1", dropCnt); end
    nVec++;
    if (!sameBytes(rxQ, want)) begin nErr++; $display("FAIL drop_chars got %p want %p", rxQ, want); end
  endtask

  task automatic test_same_cycle_repress();
    bit [7:0] want[$];
    int       n = 0;
    clearObs();
    bus.iKeys = 4'b0001; repeat (5) tick();
    bus.iKeys = 4'b0011; repeat (3) tick();
    bus.iKeys = 4'b0001;
    while (bus.oBusy !== 1'b0 && n < 200) begin tick(); n++; end
    // The next edge grants key 1; the re-press lands on that same edge.
    bus.iKeys = 4'b0011;
    repeat (3) tick();
    bus.iKeys = '0;
    waitQuiet(600);
    want.push_back(8'h30);
    want.push_back(8'h31);
    want.push_back(8'h31);
    nVec++;
    if (dropCnt != 0) begin nErr++; $display("FAIL same_cycle_drop got %0d want 0", dropCnt); end
    nVec++;
    if (!sameBytes(rxQ, want)) begin nErr++; $display("FAIL same_cycle_chars got %p want %p", rxQ, want); end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    clearObs();
    bus.iKeys = 4'b0001;
    while (fallQ.size() == 0 && n < 20) begin tick(); n++; end
    repeat (40) tick();
    #3 rst = 1'b0;
    #1;
    nVec++;
    if (bus.oTx !== 1'b1 || bus.oBusy !== 1'b0) begin
      nErr++; $display("FAIL midreset_async got tx=%b busy=%b want tx=1 busy=0", bus.oTx, bus.oBusy);
    end
    bus.iKeys = '0;
    repeat (3) tick();
    rst = 1'b1;
    clearObs();
    repeat (200) tick();
    nVec++;
    if (fallQ.size() != 0 || busyCnt != 0) begin
      nErr++; $display("FAIL midreset_no_frame got frames=%0d busy=%0d want 0/0", fallQ.size(), busyCnt);
    end
  endtask

  task automatic test_held_key();
    bit [7:0] want[$];
    clearObs();
    bus.iKeys = 4'b1000;
    repeat (500) tick();
    nVec++;
    if (bus.oTx !== 1'b1) begin nErr++; $display("FAIL held_idle_line got %b want 1", bus.oTx); end
    bus.iKeys = '0;
    waitQuiet(300);
    want.push_back(8'h33);
    nVec++;
    if (!sameBytes(rxQ, want)) begin nErr++; $display("FAIL held_chars got %p want %p", rxQ, want); end
  endtask

  task automatic test_random();
    bit [NK-1:0] k = '0;
    clearObs();
    repeat (3000) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 39) == 0) k[i] = ~k[i];
      bus.iKeys = k;
      tick();
    end
    bus.iKeys = '0;
    waitQuiet(2000);
    nVec++;
    if (rxQ.size() == 0 || !sameBytes(rxQ, expQ)) begin
      nErr++; $display("FAIL random_chars got %0d chars want %0d (nonzero, equal)", rxQ.size(), expQ.size());
    end
    nVec++;
    if (dropCnt != mdlDropCnt) begin
      nErr++; $display("FAIL random_drops got %0d want %0d", dropCnt, mdlDropCnt);
    end
  endtask

  initial begin
    bus.iKeys = '0;
    test_reset();
    test_single_press();
    test_simultaneous();
    test_drop();
    test_same_cycle_repress();
    test_reset_mid_frame();
    test_held_key();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
